// File: rtl/matrix_pkg.sv
// Shared types, mode encodings and packing helper for the sequential matrix block.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [1:0] MODE_T   = 2'd0;
    localparam logic [1:0] MODE_AAT = 2'd1;
    localparam logic [1:0] MODE_ATA = 2'd2;
    localparam logic [1:0] MODE_AA  = 2'd3;

    // Bit offset of element (i,j) in a row-major vector with (0,0) in the MSBs.
    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                             input int unsigned n, input int unsigned w);
        return (n * n - 1 - (i * n + j)) * w;
    endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Job and result handshake bundle between loader, matrix block and consumer.
interface matrix_mult_seq_if #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 4,
    parameter int unsigned RW = 8
) ();
    localparam int unsigned AW = N * N * DW;
    localparam int unsigned PW = N * N * RW;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a_in;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] t_out;
    logic [PW-1:0] r_out;
    logic          ovf;

    modport master (
        output in_valid, a_in, mode, out_ready,
        input  in_ready, out_valid, t_out, r_out, ovf
    );

    modport slave (
        input  in_valid, a_in, mode, out_ready,
        output in_ready, out_valid, t_out, r_out, ovf
    );
endinterface

// File: rtl/matrix_mac.sv
// Unsigned DW x DW multiply-accumulate with clear-on-first and a registered sum.
module matrix_mac #(
    parameter int unsigned DW    = 4,
    parameter int unsigned ACC_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             first,
    input  logic [DW-1:0]    x,
    input  logic [DW-1:0]    y,
    output logic [ACC_W-1:0] sum_c
);
    localparam int unsigned PW = 2 * DW;

    logic [PW-1:0]    prod_c;
    logic [ACC_W-1:0] acc_q;

    assign prod_c = PW'(x) * PW'(y);
    assign sum_c  = (first ? '0 : acc_q) + ACC_W'(prod_c);

    // Accumulator holds the running partial sum between MAC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum_c;
        end
    end
endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential NxN transpose plus A*A^T / A^T*A / A*A on one time-shared MAC.
module matrix_mult_seq
    import matrix_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 4,
    parameter int unsigned RW = 8
) (
    input  logic            clk,
    input  logic            rst,
    matrix_mult_seq_if.slave bus
);
    localparam int unsigned ACC_W = 2 * DW + $clog2(N);
    localparam int unsigned AW    = N * N * DW;
    localparam int unsigned IW    = $clog2(N);

    state_t           state_q, state_d;
    logic [AW-1:0]    a_q;
    logic [1:0]       mode_q;
    logic [AW-1:0]    t_q;
    logic [AW-1:0]    t_in_c;
    logic [RW-1:0]    r_arr [N][N];
    logic [DW-1:0]    a_arr [N][N];
    logic             ovf_q;
    logic             valid_q;
    logic [IW-1:0]    i_q, j_q, k_q;

    logic             accept_c;
    logic             mac_en_c;
    logic             last_i_c, last_j_c, last_k_c, last_c;
    logic [DW-1:0]    x_c, y_c;
    logic [ACC_W-1:0] sum_c;
    logic             ovf_c;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = valid_q;
    assign bus.t_out     = t_q;
    assign bus.ovf       = ovf_q;

    assign accept_c = bus.in_valid && bus.in_ready;
    assign mac_en_c = (state_q == COMPUTE);
    assign last_i_c = (i_q == IW'(N - 1));
    assign last_j_c = (j_q == IW'(N - 1));
    assign last_k_c = (k_q == IW'(N - 1));
    assign last_c   = last_i_c && last_j_c && last_k_c;

    // Unpack stored A, transpose incoming A, and pack results onto the bus.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign a_arr[r][c] = a_q[elem_lsb(r, c, N, DW) +: DW];
            assign t_in_c[elem_lsb(r, c, N, DW) +: DW] = bus.a_in[elem_lsb(c, r, N, DW) +: DW];
            assign bus.r_out[elem_lsb(r, c, N, RW) +: RW] = r_arr[r][c];
        end
    end

    // Overflow is impossible when the result width covers full precision.
    if (RW >= ACC_W) begin : g_no_ovf
        assign ovf_c = 1'b0;
    end else begin : g_ovf
        assign ovf_c = |sum_c[ACC_W-1:RW];
    end

    // Operand fetch: X[i][k] and Y[k][j], with A^T read as A with swapped indices.
    always_comb begin
        x_c = a_arr[i_q][k_q];
        y_c = a_arr[j_q][k_q];
        case (mode_q)
            MODE_ATA: begin
                x_c = a_arr[k_q][i_q];
                y_c = a_arr[k_q][j_q];
            end
            MODE_AA: begin
                x_c = a_arr[i_q][k_q];
                y_c = a_arr[k_q][j_q];
            end
            default: ;
        endcase
    end

    matrix_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_c),
        .en    (mac_en_c),
        .first (k_q == '0),
        .x     (x_c),
        .y     (y_c),
        .sum_c (sum_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = (bus.mode == MODE_T) ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job capture, index walk, result write-back and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            mode_q  <= '0;
            t_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_arr[r][c] <= '0;
                end
            end
        end else begin
            valid_q <= (state_d == DONE);
            if (accept_c) begin
                a_q    <= bus.a_in;
                mode_q <= bus.mode;
                t_q    <= t_in_c;
                ovf_q  <= 1'b0;
                i_q    <= '0;
                j_q    <= '0;
                k_q    <= '0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        r_arr[r][c] <= '0;
                    end
                end
            end else if (state_q == COMPUTE) begin
                if (last_k_c) begin
                    k_q            <= '0;
                    r_arr[i_q][j_q] <= RW'(sum_c);
                    if (ovf_c) begin
                        ovf_q <= 1'b1;
                    end
                    if (last_j_c) begin
                        j_q <= '0;
                        i_q <= last_i_c ? '0 : i_q + IW'(1);
                    end else begin
                        j_q <= j_q + IW'(1);
                    end
                end else begin
                    k_q <= k_q + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_mult_seq.sv
// Randomised and directed bench for matrix_mult_seq against a matrix-level model.
module tb_matrix_mult_seq;
    localparam int unsigned N  = 2;
    localparam int unsigned DW = 4;
    localparam int unsigned RW = 8;
    localparam int unsigned NN = N * N;
    localparam int unsigned AW = NN * DW;
    localparam int unsigned PW = NN * RW;
    localparam int          LAT_MAC = N * N * N + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    matrix_mult_seq_if #(.N(N), .DW(DW), .RW(RW)) bus ();

    matrix_mult_seq #(.N(N), .DW(DW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain matrix algebra on unpacked integer matrices.
    function automatic void model(input logic [AW-1:0] a, input logic [1:0] m,
                                  output logic [AW-1:0] t, output logic [PW-1:0] r,
                                  output logic o);
        int unsigned am [N][N];
        int unsigned at [N][N];
        int unsigned xm [N][N];
        int unsigned ym [N][N];
        int unsigned s;
        logic [PW-1:0] tmp;
        t = '0;
        r = '0;
        o = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                am[i][j] = int'((a >> ((NN - 1 - (i * N + j)) * DW)) & AW'((1 << DW) - 1));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                at[i][j] = am[j][i];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                t |= AW'(at[i][j]) << ((NN - 1 - (i * N + j)) * DW);
        if (m == 2'd0) return;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                xm[i][j] = (m == 2'd2) ? at[i][j] : am[i][j];
                ym[i][j] = (m == 2'd1) ? at[i][j] : am[i][j];
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += xm[i][k] * ym[k][j];
                if (s > (1 << RW) - 1) o = 1'b1;
                tmp = PW'(s % (1 << RW));
                r |= tmp << ((NN - 1 - (i * N + j)) * RW);
            end
    endfunction

    // Present a job and return just after the capture edge; scrambles inputs afterwards.
    task automatic start_job(input logic [AW-1:0] a, input logic [1:0] m, output bit to);
        int w = 0;
        to = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.mode     = m;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) to = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mode     = 2'($urandom);
        bus.a_in     = AW'($urandom);
    endtask

    // Count cycles from the capture edge until out_valid is seen.
    task automatic wait_valid(output int cyc, output bit to);
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        to = !bus.out_valid;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.t_out !== '0 || bus.r_out !== '0 || bus.ovf !== 1'b0)
            begin n_err++; $display("FAIL reset_outputs t=%h r=%h ovf=%b want all 0", bus.t_out, bus.r_out, bus.ovf); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [AW-1:0] va [6];
        logic [1:0]    vm [6];
        logic [AW-1:0] vt [6];
        logic [PW-1:0] vr [6];
        logic          vo [6];
        int cyc;
        bit to;
        va = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hFFFF, 16'h1234};
        vm = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1};
        vt = '{16'h1324, 16'h1324, 16'h1324, 16'h1324, 16'hFFFF, 16'h1324};
        vr = '{32'h050B0B19, 32'h0A0E0E14, 32'h070A0F16, 32'h0, 32'hC2C2C2C2, 32'h050B0B19};
        vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 6; n++) begin
            start_job(va[n], vm[n], to);
            n_cmp++; if (to) begin n_err++; $display("FAIL dir%0d_accept timeout", n); end
            wait_valid(cyc, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL dir%0d_valid timeout", n); end
            n_cmp++; if (cyc !== ((vm[n] == 2'd0) ? 1 : LAT_MAC))
                begin n_err++; $display("FAIL dir%0d_latency got=%0d want=%0d", n, cyc, (vm[n] == 2'd0) ? 1 : LAT_MAC); end
            n_cmp++; if (bus.t_out !== vt[n]) begin n_err++; $display("FAIL dir%0d_t_out got=%h want=%h", n, bus.t_out, vt[n]); end
            n_cmp++; if (bus.r_out !== vr[n]) begin n_err++; $display("FAIL dir%0d_r_out got=%h want=%h", n, bus.r_out, vr[n]); end
            n_cmp++; if (bus.ovf !== vo[n]) begin n_err++; $display("FAIL dir%0d_ovf got=%b want=%b", n, bus.ovf, vo[n]); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] et;
        logic [PW-1:0] er;
        logic          eo;
        int cyc;
        bit to;
        start_job(16'h1234, 2'd1, to);
        wait_valid(cyc, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL bp_valid timeout"); end
        bus.in_valid = 1'b1;
        bus.a_in     = 16'hABCD;
        bus.mode     = 2'd3;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                begin n_err++; $display("FAIL bp_hold%0d out_valid=%b in_ready=%b want 1/0", c, bus.out_valid, bus.in_ready); end
            n_cmp++; if (bus.t_out !== 16'h1324 || bus.r_out !== 32'h050B0B19 || bus.ovf !== 1'b0)
                begin n_err++; $display("FAIL bp_stable%0d t=%h r=%h ovf=%b want 1324/050b0b19/0", c, bus.t_out, bus.r_out, bus.ovf); end
        end
        consume();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_err++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mode     = 2'd0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_captured in_ready=%b want=0", bus.in_ready); end
        wait_valid(cyc, to);
        model(16'hABCD, 2'd3, et, er, eo);
        n_cmp++; if (to || cyc !== LAT_MAC) begin n_err++; $display("FAIL bp_next_latency got=%0d want=%0d", cyc, LAT_MAC); end
        n_cmp++; if (bus.t_out !== et || bus.r_out !== er || bus.ovf !== eo)
            begin n_err++; $display("FAIL bp_next_result t=%h r=%h ovf=%b want %h/%h/%b", bus.t_out, bus.r_out, bus.ovf, et, er, eo); end
        consume();
    endtask

    task automatic test_reset_mid_compute();
        logic [AW-1:0] et;
        logic [PW-1:0] er;
        logic          eo;
        int  cyc;
        bit  to;
        bit  seen = 1'b0;
        start_job(16'hFFFF, 2'd1, to);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready got=%b want=0", bus.in_ready); end
        n_cmp++; if (bus.t_out !== '0 || bus.r_out !== '0 || bus.ovf !== 1'b0 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL abort_clear t=%h r=%h ovf=%b v=%b want all 0", bus.t_out, bus.r_out, bus.ovf, bus.out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_valid got=%b want=0", seen); end
        start_job(16'h1234, 2'd3, to);
        wait_valid(cyc, to);
        model(16'h1234, 2'd3, et, er, eo);
        n_cmp++; if (to || cyc !== LAT_MAC) begin n_err++; $display("FAIL abort_next_latency got=%0d want=%0d", cyc, LAT_MAC); end
        n_cmp++; if (bus.t_out !== et || bus.r_out !== er || bus.ovf !== eo)
            begin n_err++; $display("FAIL abort_next_result t=%h r=%h ovf=%b want %h/%h/%b", bus.t_out, bus.r_out, bus.ovf, et, er, eo); end
        consume();
    endtask

    task automatic test_random();
        logic [AW-1:0] a, et;
        logic [PW-1:0] er;
        logic [1:0]    m;
        logic          eo;
        int cyc;
        bit to;
        for (int n = 0; n < 25; n++) begin
            a = AW'($urandom);
            m = 2'($urandom_range(0, 3));
            model(a, m, et, er, eo);
            start_job(a, m, to);
            wait_valid(cyc, to);
            n_cmp++; if (to || cyc !== ((m == 2'd0) ? 1 : LAT_MAC))
                begin n_err++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, cyc, (m == 2'd0) ? 1 : LAT_MAC); end
            n_cmp++; if (bus.t_out !== et || bus.r_out !== er || bus.ovf !== eo)
                begin n_err++; $display("FAIL rnd%0d_result a=%h m=%0d t=%h r=%h ovf=%b want %h/%h/%b", n, a, m, bus.t_out, bus.r_out, bus.ovf, et, er, eo); end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a, et;
        logic [PW-1:0] er;
        logic [1:0]    m;
        logic          eo;
        int cyc;
        bit to;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            a = AW'($urandom);
            m = 2'($urandom_range(0, 3));
            model(a, m, et, er, eo);
            start_job(a, m, to);
            wait_valid(cyc, to);
            n_cmp++; if (to || cyc !== ((m == 2'd0) ? 1 : LAT_MAC))
                begin n_err++; $display("FAIL b2b%0d_latency got=%0d want=%0d", n, cyc, (m == 2'd0) ? 1 : LAT_MAC); end
            n_cmp++; if (bus.t_out !== et || bus.r_out !== er || bus.ovf !== eo)
                begin n_err++; $display("FAIL b2b%0d_result t=%h r=%h ovf=%b want %h/%h/%b", n, bus.t_out, bus.r_out, bus.ovf, et, er, eo); end
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
                begin n_err++; $display("FAIL b2b%0d_drain out_valid=%b in_ready=%b want 0/1", n, bus.out_valid, bus.in_ready); end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.mode      = 2'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_compute();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
